ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
AHB3-Lite responder (slave end of the master modport bus) backed by an internal word-addressed SRAM array. Accepts pipelined address/data-phase transfers, inserts a configurable number of wait states, and performs byte/halfword/word writes with lane masking. Gives a two-cycle ERROR response for out-of-range, misaligned or oversize accesses. Serves as the default memory target in block-level AHB benches and the SoC fabric.

Parameters:
HADDR_SIZE, 16, address bus width
HDATA_SIZE, 32, data bus width; fixed at 32 for this block
MEM_DEPTH, 1024, number of HDATA_SIZE-bit words; must be at most 2**(HADDR_SIZE-2)
WAIT_STATES, 0, wait cycles per OKAY transfer (0..7)

Ports:
HCLK  in  1  bus clock; all logic on rising edge
HRESET  in  1  one clock; reset is synchronous and active-high
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  byte address
HWDATA  in  HDATA_SIZE  write data (data phase)
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  1=write, 0=read
HSIZE  in  3  transfer size
HBURST  in  3  burst type; ignored, each beat handled independently
HPROT  in  4  protection attributes
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HREADY  in  1  bus-level ready (previous transfer complete)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Accept condition: HSEL & HREADY & HTRANS[1]. On accept, register addr, write, size and error flag. IDLE/BUSY, or HSEL=0, gives zero-wait OKAY and no access.
- Error flag is set when any of these holds:
  - word address HADDR[HADDR_SIZE-1:2] >= MEM_DEPTH
  - HSIZE > 2
  - HSIZE=1 with HADDR[0]=1
  - HSIZE=2 with HADDR[1:0] != 0
  - (optional) the protection check below
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on accept with error -> ERR1. On accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1. On accept with WAIT_STATES=0 -> data phase completes next cycle (HREADYOUT=1), state stays IDLE.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0 the next cycle is the completing cycle (HREADYOUT=1), then the FSM re-evaluates accept.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept is evaluated in this cycle (back-to-back allowed), then -> IDLE, WAIT or ERR1.
- Latency: OKAY data phase lasts WAIT_STATES+1 cycles. ERROR lasts exactly 2 cycles regardless of WAIT_STATES.
- Write commit: on the completing OKAY cycle, HWDATA is written under byte-lane mask.
  - Byte: lane HADDR[1:0].
  - Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
  - Word: all four lanes.
  - Errored writes never modify memory.
- Read: HRDATA = mem[latched word addr] (full word, all lanes) during the completing OKAY read cycle; 0 in all other cycles, including ERROR cycles.
- RAW hazard: a read whose address phase coincides with the completing cycle of a write to the same word returns the new data.
- Reset mid-transfer: pending write is dropped, FSM returns to IDLE next cycle.

Optional Feature:
AHB_SLV_PROT_CHECK_EN
- Defined: a write with HPROT[1]=0 (user access) to word addresses in the upper quarter of MEM_DEPTH sets the error flag, giving a two-cycle ERROR and no write. Reads are unaffected.
- Undefined: HPROT is ignored entirely.

Decomposition:
- Package ahb3lite_pkg:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ)
  - hsize_t enum (BYTE/HALF/WORD)
  - HRESP_OKAY/HRESP_ERROR constants
  - slv_state_t enum (IDLE/WAIT/ERR1/ERR2)
  - byte-mask function
- Sub-module ahb3lite_sram_array: MEM_DEPTH x 32 array with 4-bit byte-enable synchronous write and combinational read. The FSM and pipeline registers stay in the top.

Test Plan:
1. WAIT_STATES=0: NONSEQ write word 0xDEADBEEF @0x0010, then read @0x0010 -> HREADYOUT never low; read data phase HRDATA=0xDEADBEEF, HRESP=0.
2. WAIT_STATES=3: read @0x0004 -> HREADYOUT low exactly 3 cycles, high on 4th with data.
3. Byte write 0xAA @0x0021 over word 0x11223344 @0x0020, then halfword write 0xBEEF @0x0022 -> word read @0x0020 = 0xBEEFAA44.
4. Word read @0x1000 (MEM_DEPTH=1024) and halfword @0x0001 -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1. Memory unchanged. Next NONSEQ accepted in ERR2 completes OKAY.
5. Back-to-back: write 0x5 @0x8 with read @0x8 in its completing cycle -> read returns 0x5. Interleave IDLE and BUSY -> OKAY, zero wait.
6. HRESET asserted during WAIT of a write (WAIT_STATES=2) -> HREADYOUT=1, HRESP=0 next cycle; subsequent read shows old data. With AHB_SLV_PROT_CHECK_EN: user write @0x0F00 -> ERROR.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared AHB3-Lite types and helpers for the SRAM responder:
//   htrans_t    - transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_t     - supported transfer sizes (BYTE/HALF/WORD)
//   HRESP_*     - response encodings
//   slv_state_t - responder FSM states
//   byte_mask() - byte-lane enable for a size/offset pair
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } slv_state_t;

    // Lane enables for a 32-bit word. size is HSIZE[1:0] of an accepted
    // (already size-checked) transfer, off is HADDR[1:0].
    function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            2'd0:    mask = 4'b0001 << off;
            2'd1:    mask = off[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb3lite_sram_array.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_array
// MEM_DEPTH x 32-bit storage with byte-enable synchronous write and
// combinational (asynchronous) read on a single shared address.
// Ports:
//   clk    in   write clock
//   addr   in   word address (read and write)
//   be     in   4-bit byte-lane write enable
//   wdata  in   write data
//   rdata  out  read data, mem[addr]
// ---------------------------------------------------------------------------
module ahb3lite_sram_array #(
    parameter int MEM_DEPTH = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // NOTE: storage has no reset; clearing a RAM costs a port per word and
    // software never relies on power-up contents.
    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_slave
// AHB3-Lite responder backed by an internal SRAM. Pipelined address/data
// phases, WAIT_STATES wait cycles per OKAY transfer, byte/half/word writes
// with lane masking, two-cycle ERROR for out-of-range, misaligned or
// oversize accesses.
// Optional build macro AHB_SLV_PROT_CHECK_EN: user-mode (HPROT[1]=0) writes
// to the upper quarter of the array are answered with ERROR.
// Ports:
//   HCLK, HRESET (sync, active-high)
//   HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY  address phase
//   HWDATA                                                     data phase
//   HRDATA, HREADYOUT, HRESP                                   responses
// ---------------------------------------------------------------------------
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int         AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES - 1);

    slv_state_t      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            dphase_q, dphase_d;   // OKAY transfer in its data phase
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            write_q, write_d;

    logic [HADDR_SIZE-3:0] word_addr;
    logic                  accept;
    logic                  req_err;
    logic                  complete;
    logic [3:0]            be;
    logic [31:0]           rdata;

    assign word_addr = HADDR[HADDR_SIZE-1:2];
    assign accept    = HSEL & HREADY & HTRANS[1];

    always_comb begin
        req_err = (32'(word_addr) >= 32'(MEM_DEPTH))
                | (HSIZE > HSIZE_WORD)
                | ((HSIZE == HSIZE_HALF) & HADDR[0])
                | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));
`ifdef AHB_SLV_PROT_CHECK_EN
        req_err = req_err
                | (HWRITE & ~HPROT[1]
                   & (32'(word_addr) >= 32'(MEM_DEPTH - MEM_DEPTH / 4)));
`endif
    end

    // HBURST is ignored (each beat is independent); HPROT only matters when
    // the protection check is built in.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT};

    // The completing cycle of an OKAY transfer is always spent in IDLE with a
    // pending data phase, whether or not wait states preceded it.
    assign complete = (state_q == S_IDLE) & dphase_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        dphase_d  = dphase_q;
        addr_d    = addr_q;
        off_d     = off_q;
        size_d    = size_q;
        write_d   = write_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;

        unique case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 3'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                HRESP = HRESP_ERROR;
            end
        endcase

        // IDLE and ERR2 are the only HREADYOUT=1 cycles, so a new address
        // phase can only be taken there.
        if (state_q == S_IDLE || state_q == S_ERR2) begin
            state_d  = S_IDLE;
            dphase_d = 1'b0;
            if (accept) begin
                addr_d  = HADDR[AW+1:2];
                off_d   = HADDR[1:0];
                size_d  = HSIZE[1:0];
                write_d = HWRITE;
                if (req_err) begin
                    state_d = S_ERR1;
                end else begin
                    dphase_d = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            dphase_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dphase_q <= dphase_d;
        end
    end

    // Address-phase capture is qualified by dphase_q/state_q, so it needs no
    // reset.
    always_ff @(posedge HCLK) begin
        addr_q  <= addr_d;
        off_q   <= off_d;
        size_q  <= size_d;
        write_q <= write_d;
    end

    // A reset landing on the completing cycle still drops the write.
    assign be = byte_mask(size_q, off_q) & {4{complete & write_q & ~HRESET}};

    ahb3lite_sram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_array (
        .clk   (HCLK),
        .addr  (addr_q),
        .be    (be),
        .wdata (HWDATA),
        .rdata (rdata)
    );

    assign HRDATA = (complete & ~write_q) ? rdata : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
`timescale 1ns/1ps
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    // Three responders differing only in WAIT_STATES share one bus; sel picks
    // which one is addressed and which one drives the bus-level HREADY.
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel_bus;
    logic [15:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    int          sel;
    logic [2:0]  hsel;
    logic        hready_bus;
    logic [31:0] hrdata    [3];
    logic        hreadyout [3];
    logic        hresp     [3];

    assign hsel[0]    = hsel_bus && (sel == 0);
    assign hsel[1]    = hsel_bus && (sel == 1);
    assign hsel[2]    = hsel_bus && (sel == 2);
    assign hready_bus = (sel == 2) ? hreadyout[2] : (sel == 1) ? hreadyout[1] : hreadyout[0];

    always #5 HCLK = ~HCLK;

    ahb3lite_sram_slave #(.WAIT_STATES(0)) u_dut_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(hrdata[0]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HREADY(hready_bus), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

    ahb3lite_sram_slave #(.WAIT_STATES(2)) u_dut_ws2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(hrdata[1]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HREADY(hready_bus), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

    ahb3lite_sram_slave #(.WAIT_STATES(3)) u_dut_ws3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(hrdata[2]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HREADY(hready_bus), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]));

    function automatic int ws_of(input int s);
        case (s)
            1:       return 2;
            2:       return 3;
            default: return 0;
        endcase
    endfunction

    typedef struct {
        int          s;
        logic        err;
        int          waits;
        logic [31:0] rdata;
        string       tag;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mdl [int];
    int          n_total = 0;
    int          n_bad   = 0;
    int          lowcnt  = 0;
    int          beat_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input logic [15:0] a, input logic w,
                                   input logic [2:0] sz, input logic [3:0] pr);
        bit e;
        e = ((a >> 2) >= 16'd1024) || (sz > 3'd2)
            || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
`ifdef AHB_SLV_PROT_CHECK_EN
        e = e || (w && !pr[1] && ((a >> 2) >= 16'd768));
`else
        if (w && pr[1]) e = e;
`endif
        return e;
    endfunction

    // Issue one address phase, wait for it to be accepted, push the expected
    // data-phase outcome, then drive its write data.
    task automatic beat(input int s, input logic [1:0] tr, input logic [15:0] a,
                        input logic w, input logic [2:0] sz, input logic [31:0] wd,
                        input logic [3:0] pr);
        logic        rdy;
        int          guard;
        exp_t        e;
        int          key;
        logic [3:0]  m;
        logic [31:0] old;
        sel      = s;
        hsel_bus = 1'b1;
        HTRANS   = tr;
        HADDR    = a;
        HWRITE   = w;
        HSIZE    = sz;
        HPROT    = pr;
        HBURST   = 3'd0;
        guard    = 0;
        do begin
            @(negedge HCLK);
            rdy = hready_bus;
            @(posedge HCLK);
            guard++;
        end while (!rdy && guard < 32);
        if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
        beat_no++;
        e.s     = s;
        e.tag   = $sformatf("b%0d_%s@%h", beat_no, w ? "wr" : "rd", a);
        e.err   = tr[1] && exp_err(a, w, sz, pr);
        e.waits = !tr[1] ? 0 : e.err ? 1 : ws_of(s);
        e.rdata = 32'd0;
        key     = s * 65536 + int'(a >> 2);
        if (tr[1] && !e.err) begin
            if (w) begin
                case (sz)
                    3'd0:    m = 4'b0001 << a[1:0];
                    3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
                    default: m = 4'b1111;
                endcase
                old = mdl.exists(key) ? mdl[key] : 32'd0;
                for (int i = 0; i < 4; i++)
                    if (m[i]) old[8*i +: 8] = wd[8*i +: 8];
                mdl[key] = old;
            end else begin
                e.rdata = mdl.exists(key) ? mdl[key] : 32'd0;
            end
        end
        exp_q.push_back(e);
        #1;
        HWDATA = wd;
    endtask

    task automatic flush(input int s);
        beat(s, HTRANS_IDLE, 16'h0, 1'b0, 3'd2, 32'd0, 4'b0011);
        hsel_bus = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge HCLK);
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        #1;
    endtask

    // Data-phase monitor: every cycle with a pending expectation, check the
    // selected responder's outputs; pop on the completing cycle.
    exp_t mon_e;
    always @(negedge HCLK) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q[0];
            if (!hreadyout[mon_e.s]) begin
                check({mon_e.tag, "_wait_resp"}, 32'(hresp[mon_e.s]), 32'(mon_e.err));
                check({mon_e.tag, "_wait_rdata"}, hrdata[mon_e.s], 32'd0);
                lowcnt++;
                if (lowcnt > 20) begin
                    check({mon_e.tag, "_stall"}, lowcnt, mon_e.waits);
                    void'(exp_q.pop_front());
                    lowcnt = 0;
                end
            end else begin
                check({mon_e.tag, "_resp"}, 32'(hresp[mon_e.s]), 32'(mon_e.err));
                check({mon_e.tag, "_waits"}, lowcnt, mon_e.waits);
                check({mon_e.tag, "_rdata"}, hrdata[mon_e.s], mon_e.rdata);
                void'(exp_q.pop_front());
                lowcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rdy;
        HRESET   = 1'b1;
        hsel_bus = 1'b0;
        sel      = 0;
        HADDR    = '0;
        HWDATA   = '0;
        HWRITE   = 1'b0;
        HSIZE    = 3'd2;
        HBURST   = 3'd0;
        HPROT    = 4'b0011;
        HTRANS   = HTRANS_IDLE;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_hreadyout%0d", i), 32'(hreadyout[i]), 32'd1);
            check($sformatf("rst_hresp%0d", i), 32'(hresp[i]), 32'd0);
            check($sformatf("rst_hrdata%0d", i), hrdata[i], 32'd0);
        end
        @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Zero-wait write then pipelined read of the same word.
        beat(0, HTRANS_NONSEQ, 16'h0010, 1'b1, 3'd2, 32'hDEADBEEF, 4'b0011);
        beat(0, HTRANS_NONSEQ, 16'h0010, 1'b0, 3'd2, 32'd0, 4'b0011);
        flush(0);

        // Lane masking: word, byte at offset 1, halfword at offset 2.
        beat(0, HTRANS_NONSEQ, 16'h0020, 1'b1, 3'd2, 32'h11223344, 4'b0011);
        beat(0, HTRANS_SEQ,    16'h0021, 1'b1, 3'd0, 32'h0000AA00, 4'b0011);
        beat(0, HTRANS_SEQ,    16'h0022, 1'b1, 3'd1, 32'hBEEF0000, 4'b0011);
        beat(0, HTRANS_NONSEQ, 16'h0020, 1'b0, 3'd2, 32'd0, 4'b0011);
        flush(0);

        // Read-after-write in the write's completing cycle; IDLE and BUSY.
        beat(0, HTRANS_NONSEQ, 16'h0008, 1'b1, 3'd2, 32'h00000005, 4'b0011);
        beat(0, HTRANS_NONSEQ, 16'h0008, 1'b0, 3'd2, 32'd0, 4'b0011);
        beat(0, HTRANS_IDLE,   16'h0008, 1'b0, 3'd2, 32'd0, 4'b0011);
        beat(0, HTRANS_BUSY,   16'h0008, 1'b1, 3'd2, 32'hFFFFFFFF, 4'b0011);
        beat(0, HTRANS_NONSEQ, 16'h0008, 1'b0, 3'd2, 32'd0, 4'b0011);
        flush(0);

        // ERROR responses back-to-back, then an OKAY accepted in ERR2; the
        // errored halfword write must leave word 0 intact.
        for (int s = 0; s < 3; s += 2) begin
            beat(s, HTRANS_NONSEQ, 16'h0000, 1'b1, 3'd2, 32'hCAFEF00D, 4'b0011);
            beat(s, HTRANS_NONSEQ, 16'h1000, 1'b0, 3'd2, 32'd0, 4'b0011);
            beat(s, HTRANS_NONSEQ, 16'h0001, 1'b1, 3'd1, 32'h0000FFFF, 4'b0011);
            beat(s, HTRANS_NONSEQ, 16'h0000, 1'b0, 3'd2, 32'd0, 4'b0011);
            beat(s, HTRANS_NONSEQ, 16'h0004, 1'b0, 3'd3, 32'd0, 4'b0011);
            beat(s, HTRANS_NONSEQ, 16'h0000, 1'b0, 3'd0, 32'd0, 4'b0011);
            flush(s);
        end

        // Three wait states.
        beat(2, HTRANS_NONSEQ, 16'h0004, 1'b1, 3'd2, 32'hA5A50F0F, 4'b0011);
        beat(2, HTRANS_NONSEQ, 16'h0004, 1'b0, 3'd2, 32'd0, 4'b0011);
        flush(2);

        // Reset during the wait states of a write drops that write.
        beat(1, HTRANS_NONSEQ, 16'h0030, 1'b1, 3'd2, 32'h12345678, 4'b0011);
        flush(1);
        sel      = 1;
        hsel_bus = 1'b1;
        HTRANS   = HTRANS_NONSEQ;
        HADDR    = 16'h0030;
        HWRITE   = 1'b1;
        HSIZE    = 3'd2;
        @(negedge HCLK);
        rdy = hready_bus;
        check("rst_mid_accept", 32'(rdy), 32'd1);
        @(posedge HCLK);
        #1;
        HWDATA   = 32'h99999999;
        HTRANS   = HTRANS_IDLE;
        hsel_bus = 1'b0;
        @(negedge HCLK);
        check("rst_mid_waiting", 32'(hreadyout[1]), 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        check("rst_mid_hreadyout", 32'(hreadyout[1]), 32'd1);
        check("rst_mid_hresp", 32'(hresp[1]), 32'd0);
        check("rst_mid_hrdata", hrdata[1], 32'd0);
        @(posedge HCLK);
        #1;
        beat(1, HTRANS_NONSEQ, 16'h0030, 1'b0, 3'd2, 32'd0, 4'b0011);
        flush(1);

        // User-mode write to the upper quarter (ERROR only with the
        // protection check built in); reads there are never blocked.
        beat(0, HTRANS_NONSEQ, 16'h0F00, 1'b1, 3'd2, 32'h600DF00D, 4'b0011);
        beat(0, HTRANS_NONSEQ, 16'h0F00, 1'b1, 3'd2, 32'h0BADC0DE, 4'b0001);
        beat(0, HTRANS_NONSEQ, 16'h0F00, 1'b0, 3'd2, 32'd0, 4'b0001);
        flush(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
